// File: rtl/depacketizer.sv
// Receive-side deframer: hunts the 48-bit sync word, parses the modulation byte
// and length field, then forwards exactly the payload symbols as an AXIS packet.
module depacketizer #(
  parameter int          SYNC_MAX_ERR = 2,
  parameter logic [15:0] MAX_LEN      = 16'd8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_enable,
  input  logic        enable,
  input  logic [1:0]  in_tdata,
  input  logic        in_tvalid,
  output logic        in_tready,
  output logic [1:0]  out_tdata,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic        out_tlast,
  output logic        out_tuser,
  output logic [15:0] pld_len,
  output logic        is_bpsk,
  output logic        hdr_ok,
  output logic        hdr_err,
  output logic        pkt_done,
  output logic        busy
);
  typedef enum logic [1:0] {SEARCH, HDR, PLD} state_t;
  localparam logic [47:0] SYNC = 48'h5555_AAAA_AAAA;

  state_t      state;
  logic [47:0] sreg;
  logic [5:0]  hdr_cnt;
  logic [3:0]  mod_cnt;
  logic [15:0] pld_syms;
  logic [15:0] pld_cnt;

  logic        accept;
  logic        xfer;
  logic [47:0] window;
  logic        sync_hit;
  logic        hdr_bpsk;
  logic        hdr_bad;
  logic        last_sym;

  always_comb begin
    in_tready = 1'b0;
    if (clk_enable) in_tready = (state == PLD) ? (out_tready || !out_tvalid) : 1'b1;
  end

  assign accept   = in_tvalid && in_tready;
  assign xfer     = out_tvalid && out_tready;
  assign window   = {sreg[46:0], in_tdata[0]};
  assign sync_hit = ($countones(window ^ SYNC) <= SYNC_MAX_ERR);
  assign hdr_bpsk = (mod_cnt >= 4'd5);
  assign hdr_bad  = (mod_cnt == 4'd4) || (pld_len == 16'd0) || (pld_len > MAX_LEN) ||
                    (!hdr_bpsk && pld_len[0]);
  assign last_sym = (pld_cnt == pld_syms - 16'd1);
  assign busy     = (state != SEARCH);
  // An abort (enable low) drops the pending beat, so it never completes a packet.
  assign pkt_done = rst_n && clk_enable && enable && xfer && out_tlast;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SEARCH;
      sreg       <= '0;
      hdr_cnt    <= '0;
      mod_cnt    <= '0;
      pld_syms   <= '0;
      pld_cnt    <= '0;
      pld_len    <= '0;
      is_bpsk    <= 1'b0;
      hdr_ok     <= 1'b0;
      hdr_err    <= 1'b0;
      out_tdata  <= '0;
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
      out_tuser  <= 1'b0;
    end else if (clk_enable) begin
      hdr_ok  <= 1'b0;
      hdr_err <= 1'b0;
      if (!enable) begin
        state      <= SEARCH;
        sreg       <= '0;
        out_tvalid <= 1'b0;
        out_tlast  <= 1'b0;
      end else begin
        case (state)
          SEARCH: begin
            if (xfer) begin
              out_tvalid <= 1'b0;
              out_tlast  <= 1'b0;
            end
            // No relock while the previous packet's last beat is still pending.
            if (accept) begin
              if (sync_hit && !out_tvalid) begin
                state   <= HDR;
                hdr_cnt <= '0;
                mod_cnt <= '0;
                sreg    <= '0;
              end else begin
                sreg <= window;
              end
            end
          end
          HDR: begin
            if (accept) begin
              hdr_cnt <= hdr_cnt + 6'd1;
              if (hdr_cnt < 6'd8) begin
                if (in_tdata[0] == ~hdr_cnt[0]) mod_cnt <= mod_cnt + 4'd1;
              end else if (hdr_cnt < 6'd24) begin
                pld_len <= {pld_len[14:0], in_tdata[0]};
              end
              if (hdr_cnt == 6'd63) begin
                if (hdr_bad) begin
                  hdr_err <= 1'b1;
                  state   <= SEARCH;
                  sreg    <= '0;
                end else begin
                  hdr_ok   <= 1'b1;
                  is_bpsk  <= hdr_bpsk;
                  pld_syms <= hdr_bpsk ? pld_len : {1'b0, pld_len[15:1]};
                  pld_cnt  <= '0;
                  state    <= PLD;
                end
              end
            end
          end
          PLD: begin
            if (accept) begin
              out_tdata  <= is_bpsk ? {1'b0, in_tdata[0]} : in_tdata;
              out_tvalid <= 1'b1;
              out_tuser  <= is_bpsk;
              out_tlast  <= last_sym;
              pld_cnt    <= pld_cnt + 16'd1;
              if (last_sym) state <= SEARCH;
            end else if (out_tready) begin
              out_tvalid <= 1'b0;
              out_tlast  <= 1'b0;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end
endmodule

// File: doc/depacketizer.md
Name: depacketizer

Overview:
- Receive-side counterpart of the MIX-mode packet framer.
- Consumes hard-decision demodulated symbols and hunts for the frame sync word in the preamble.
- Parses the modulation byte and the 16-bit length field, skips header padding, then forwards exactly the payload symbols as an AXIS packet with tlast.
- Sits between the symbol demapper and the payload sink or FIFO.

Parameters:
- SYNC_MAX_ERR, 2, max Hamming distance accepted when matching the 48-bit sync word.
- MAX_LEN, 16'd8192, largest legal payload_length field (in bits); larger values are rejected.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- clk_enable  in  1  when low, all state, counters and outputs hold; in_tready is forced 0.
- enable  in  1  when low, the FSM is forced to SEARCH.
- in_tdata  in  2  symbol; bit0 is the BPSK bit (header and BPSK payload); [1:0] is the QPSK dibit.
- in_tvalid  in  1  input valid.
- in_tready  out  1  input ready (combinational).
- out_tdata  out  2  payload symbol.
- out_tvalid  out  1  output valid.
- out_tready  in  1  output ready.
- out_tlast  out  1  asserted on the last payload symbol.
- out_tuser  out  1  1 = BPSK payload, 0 = QPSK.
- pld_len  out  16  latched length field, in bits.
- is_bpsk  out  1  latched modulation flag.
- hdr_ok  out  1  one-cycle pulse when a header is accepted.
- hdr_err  out  1  one-cycle pulse when a header is rejected.
- pkt_done  out  1  one-cycle pulse when out_tlast transfers.
- busy  out  1  high while in HDR or PLD.

Behaviour:
- Reset values: all outputs 0, except in_tready = 1 (SEARCH). Sync shift register 0, counters 0.
- Acceptance: a symbol is accepted when in_tvalid && in_tready && clk_enable.
- FSM states: SEARCH, HDR, PLD.
- SEARCH:
  - in_tready = 1.
  - 48-bit shift register shifts in in_tdata[0] on each accept; the oldest bit is the MSB.
  - Match window = {sreg[46:0], new bit}, compared against SYNC = 48'h5555_AAAA_AAAA.
  - If popcount(window ^ SYNC) <= SYNC_MAX_ERR, go to HDR next cycle with hdr_cnt = 0.
- HDR:
  - in_tready = 1; hdr_cnt increments per accept over 0..63.
  - Symbols 0..7 are the modulation byte; count matches against pattern 1,0,1,0,1,0,1,0. 5 or more matches = BPSK, 3 or fewer = QPSK, exactly 4 = error.
  - Symbols 8..23 are the length field, MSB first, shifted into pld_len.
  - Symbols 24..63 are padding; they are consumed and not checked.
  - On accepting symbol 63, evaluate the header. Error if:
    - modulation byte is ambiguous (4 matches), or
    - length == 0, or
    - length > MAX_LEN, or
    - QPSK with odd length.
  - On error: hdr_err pulse, go to SEARCH, clear the shift register.
  - Otherwise: hdr_ok pulse, latch is_bpsk, set pld_syms = is_bpsk ? len : len >> 1, set pld_cnt = 0, go to PLD.
- PLD:
  - in_tready = out_tready || !out_tvalid (single output register, no bubble).
  - On each accept: out_tdata <= is_bpsk ? {1'b0, in_tdata[0]} : in_tdata; out_tvalid <= 1; out_tuser <= is_bpsk; out_tlast <= (pld_cnt == pld_syms - 1); pld_cnt increments.
  - If out_tready is high and there is no accept, out_tvalid clears.
  - When the last symbol is accepted, go to SEARCH. The output register still drains: out_tvalid/out_tlast are held until out_tready.
  - pkt_done pulses on the cycle out_tlast transfers.
  - A payload of 1 symbol is legal: the first symbol carries tlast.
- Latency: one cycle from input accept to out_tvalid.
- Transfer counts: exactly pld_syms output transfers per packet. Input accepted beyond the last payload symbol is treated as SEARCH data, never forwarded.
- Search gating: the output register may still hold the last symbol while in SEARCH. No new match is taken until out_tvalid is 0; in_tready stays 1 and the shift register keeps shifting.
- enable low mid-packet: state goes to SEARCH next cycle, shift register cleared, out_tvalid/out_tlast cleared without handshake, no pkt_done. This is an abort: the sink sees a truncated packet with no tlast.
- rst_n low at any point: everything returns to reset values next edge; any pending output is dropped.
- hdr_ok, hdr_err and pkt_done are never asserted in the same cycle, except that pkt_done may coincide with nothing else.

Test Plan:
- Full BPSK frame: 256-bit preamble (alternating, phase flip at bit 224), mod byte 0xAA, length 16'd12, 40-bit pad 0x5555555555, then 12 payload bits, out_tready = 1. Required: hdr_ok once; 12 output beats matching the input bits; out_tlast on beat 12; out_tuser = 1; pkt_done once.
- QPSK frame: mod byte 0x55, length 16'd10, 5 dibits 3,0,2,1,3. Required: 5 beats with those values; tlast on the 5th; out_tuser = 0.
- Sync with 2 flipped bits in the last 48 preamble bits: required lock (hdr_ok). Same frame with 3 flipped bits: required no lock and no output.
- Header rejects, each followed by hdr_err pulse and return to SEARCH with no output beats:
  - length 16'd0,
  - length 16'd9000,
  - QPSK with length 16'd7,
  - mod byte 0xA5 (4 matches).
- Backpressure: BPSK length 8, out_tready toggling 1,0,0,1 repeating. Required: in_tready low whenever out_tvalid && !out_tready; 8 beats in order; no duplicated or dropped symbols.
- Abort: enable low after the 3rd payload symbol. Required: out_tvalid 0 next cycle, no pkt_done. A following clean frame then decodes fully.
